// File: rtl/time_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-time to BCD converter:
// FSM encoding, digit-pair payload, blank code and parameter defaults.
package time_to_bcd_seq_pkg;

  localparam int unsigned DEF_NUM_FIELDS = 3;
  localparam int unsigned DEF_BIN_WIDTH  = 6;
  localparam int unsigned DEF_HOURS_IDX  = 2;
  localparam int unsigned DIGITS_W       = 8;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [7:0] OVF_DIGITS = 8'h99;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_pair_t;

endpackage

// File: rtl/time_to_bcd_seq_dd_step.sv
// One double-dabble iteration: add 3 to any BCD digit >= 5, then shift the
// combined {tens, units, binary} register left by one.
module bcd_dd_step
  import time_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = DEF_BIN_WIDTH
) (
  input  logic [DIGITS_W-1:0]  bcd_i,
  input  logic [BIN_WIDTH-1:0] bin_i,
  output logic [DIGITS_W-1:0]  bcd_c_o,
  output logic [BIN_WIDTH-1:0] bin_c_o
);

  localparam int unsigned SR_W = DIGITS_W + BIN_WIDTH;

  logic [DIGITS_W-1:0] adj_c;
  logic [SR_W-1:0]     sh_c;

  always_comb begin
    adj_c = bcd_i;
    if (bcd_i[3:0] >= 4'd5) adj_c[3:0] = bcd_i[3:0] + 4'd3;
    if (bcd_i[7:4] >= 4'd5) adj_c[7:4] = bcd_i[7:4] + 4'd3;
    sh_c    = {adj_c, bin_i} << 1;
    bcd_c_o = sh_c[SR_W-1:BIN_WIDTH];
    bin_c_o = sh_c[BIN_WIDTH-1:0];
  end

endmodule

// File: rtl/time_to_bcd_seq.sv
// Iterative binary time-field to BCD converter: one shared double-dabble
// step walks the fields in turn, with optional 12h remap and hours blanking.
module time_to_bcd_seq
  import time_to_bcd_seq_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = DEF_NUM_FIELDS,
  parameter int unsigned BIN_WIDTH  = DEF_BIN_WIDTH,
  parameter int unsigned HOURS_IDX  = DEF_HOURS_IDX
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [NUM_FIELDS*BIN_WIDTH-1:0] i_fields,
  input  logic                           i_mode_12h,
  input  logic                           i_blank_lz,
  output logic [NUM_FIELDS*DIGITS_W-1:0] o_bcd,
  output logic                           o_valid,
  output logic                           o_pm,
  output logic [NUM_FIELDS-1:0]          o_overflow
);

  localparam int unsigned FW    = NUM_FIELDS * BIN_WIDTH;
  localparam int unsigned IDX_W = $clog2(NUM_FIELDS + 1);
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH);

  state_e                         state_q;
  logic [IDX_W-1:0]               idx_q;
  logic [CNT_W-1:0]               cnt_q;
  bcd_pair_t                      sr_bcd_q;
  logic [BIN_WIDTH-1:0]           sr_bin_q;
  logic [FW-1:0]                  fields_q;
  logic                           mode12_q;
  logic                           blank_q;
  logic                           cur_ovf_q;
  logic                           pm_cur_q;
  logic [NUM_FIELDS*DIGITS_W-1:0] slots_q;
  logic [NUM_FIELDS-1:0]          ovf_slots_q;
  logic [NUM_FIELDS*DIGITS_W-1:0] bcd_q;
  logic                           pm_q;
  logic [NUM_FIELDS-1:0]          ovf_q;
  logic                           valid_q;
  logic                           ready_q;

  logic [IDX_W-1:0]     load_idx_d;
  logic [FW-1:0]        load_src_d;
  logic                 load_m12_d;
  logic [BIN_WIDTH-1:0] load_raw_d;
  logic [BIN_WIDTH-1:0] load_val_d;
  logic                 load_ovf_d;
  int unsigned          raw_u_d;
  logic [BIN_WIDTH-1:0] hours_in_d;
  logic                 pm_in_d;
  bcd_pair_t            store_d;
  logic [DIGITS_W-1:0]  dd_bcd_c;
  logic [BIN_WIDTH-1:0] dd_bin_c;

  bcd_dd_step #(
    .BIN_WIDTH(BIN_WIDTH)
  ) u_dd_step (
    .bcd_i  (sr_bcd_q),
    .bin_i  (sr_bin_q),
    .bcd_c_o(dd_bcd_c),
    .bin_c_o(dd_bin_c)
  );

  // Next field to load: field 0 from the live inputs on accept, else the snapshot.
  always_comb begin
    load_idx_d = '0;
    load_src_d = i_fields;
    load_m12_d = i_mode_12h;
    if (state_q != ST_IDLE) begin
      load_idx_d = idx_q + IDX_W'(1);
      load_src_d = fields_q;
      load_m12_d = mode12_q;
    end
    load_raw_d = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      if (load_idx_d == IDX_W'(i)) load_raw_d = load_src_d[i*BIN_WIDTH +: BIN_WIDTH];
    end
    raw_u_d    = 32'(load_raw_d);
    load_val_d = load_raw_d;
    if (load_m12_d && (32'(load_idx_d) == HOURS_IDX)) begin
      if (raw_u_d == 32'd0) load_val_d = BIN_WIDTH'(12);
      else if ((raw_u_d >= 32'd13) && (raw_u_d <= 32'd23)) load_val_d = BIN_WIDTH'(raw_u_d - 32'd12);
    end
    load_ovf_d = (raw_u_d > 32'd99);

    hours_in_d = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      if (i == HOURS_IDX) hours_in_d = i_fields[i*BIN_WIDTH +: BIN_WIDTH];
    end
    pm_in_d = (HOURS_IDX < NUM_FIELDS) && (32'(hours_in_d) >= 32'd12);
  end

  // Digits committed for the current field, with saturation and tens blanking.
  always_comb begin
    store_d = sr_bcd_q;
    if (cur_ovf_q) begin
      store_d = OVF_DIGITS;
    end else if (blank_q && mode12_q && (32'(idx_q) == HOURS_IDX) && (sr_bcd_q.tens == 4'd0)) begin
      store_d.tens = BLANK_CODE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      sr_bcd_q    <= '0;
      sr_bin_q    <= '0;
      fields_q    <= '0;
      mode12_q    <= 1'b0;
      blank_q     <= 1'b0;
      cur_ovf_q   <= 1'b0;
      pm_cur_q    <= 1'b0;
      slots_q     <= '0;
      ovf_slots_q <= '0;
      bcd_q       <= '0;
      pm_q        <= 1'b0;
      ovf_q       <= '0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid && ready_q) begin
            fields_q  <= i_fields;
            mode12_q  <= i_mode_12h;
            blank_q   <= i_blank_lz;
            pm_cur_q  <= pm_in_d;
            idx_q     <= '0;
            cnt_q     <= '0;
            sr_bcd_q  <= '0;
            sr_bin_q  <= load_val_d;
            cur_ovf_q <= load_ovf_d;
            ready_q   <= 1'b0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          sr_bcd_q <= dd_bcd_c;
          sr_bin_q <= dd_bin_c;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_WIDTH - 1)) state_q <= ST_STORE;
        end
        ST_STORE: begin
          for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              slots_q[i*DIGITS_W +: DIGITS_W] <= store_d;
              ovf_slots_q[i]                  <= cur_ovf_q;
            end
          end
          if (idx_q == IDX_W'(NUM_FIELDS - 1)) begin
            state_q <= ST_DONE;
          end else begin
            idx_q     <= load_idx_d;
            cnt_q     <= '0;
            sr_bcd_q  <= '0;
            sr_bin_q  <= load_val_d;
            cur_ovf_q <= load_ovf_d;
            state_q   <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          bcd_q   <= slots_q;
          pm_q    <= pm_cur_q;
          ovf_q   <= ovf_slots_q;
          valid_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_bcd      = bcd_q;
  assign o_pm       = pm_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_time_to_bcd_seq.sv
// Scoreboard bench for time_to_bcd_seq: default instance plus a 7-bit-field
// instance for the >99 saturation path.
module tb_time_to_bcd_seq;

  typedef struct packed {
    logic [23:0] bcd;
    logic        pm;
    logic [2:0]  ovf;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic [17:0] i_fields = '0;
  logic        i_mode_12h = 1'b0;
  logic        i_blank_lz = 1'b0;
  logic        o_ready;
  logic [23:0] o_bcd;
  logic        o_valid;
  logic        o_pm;
  logic [2:0]  o_overflow;

  logic        v7 = 1'b0;
  logic [20:0] f7 = '0;
  logic        m7 = 1'b0;
  logic        b7 = 1'b0;
  logic        ready7;
  logic [23:0] bcd7;
  logic        valid7;
  logic        pm7;
  logic [2:0]  ovf7;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];
  exp_t sb7_q[$];

  time_to_bcd_seq dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_fields(i_fields), .i_mode_12h(i_mode_12h), .i_blank_lz(i_blank_lz),
    .o_bcd(o_bcd), .o_valid(o_valid), .o_pm(o_pm), .o_overflow(o_overflow)
  );

  time_to_bcd_seq #(.NUM_FIELDS(3), .BIN_WIDTH(7), .HOURS_IDX(2)) dut7 (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(v7), .o_ready(ready7),
    .i_fields(f7), .i_mode_12h(m7), .i_blank_lz(b7),
    .o_bcd(bcd7), .o_valid(valid7), .o_pm(pm7), .o_overflow(ovf7)
  );

  initial forever #5 i_clk = ~i_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached with checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: arithmetic decimal split, independent of the shift-add datapath.
  function automatic exp_t model(input logic [20:0] f, input int bw, input logic m12, input logic blk);
    exp_t e;
    int v, t, u;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      v = int'(f >> (i * bw)) % (1 << bw);
      if (i == 2) begin
        e.pm = (v >= 12);
        if (m12) begin
          if (v == 0) v = 12;
          else if (v >= 13 && v <= 23) v = v - 12;
        end
      end
      if (v > 99) begin
        e.ovf[i] = 1'b1;
        t = 9;
        u = 9;
      end else begin
        t = v / 10;
        u = v % 10;
      end
      if (i == 2 && m12 && blk && t == 0) t = 15;
      e.bcd[i*8 +: 8] = {4'(t), 4'(u)};
    end
    return e;
  endfunction

  initial begin : mon_main
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: o_valid with o_bcd=%h but no request pending", o_bcd);
        end else begin
          e = sb_q.pop_front();
          if (o_bcd !== e.bcd) begin failures++; $display("FAIL sb_bcd: got %h expected %h", o_bcd, e.bcd); end
          checks++;
          if (o_pm !== e.pm) begin failures++; $display("FAIL sb_pm: got %b expected %b", o_pm, e.pm); end
          checks++;
          if (o_overflow !== e.ovf) begin failures++; $display("FAIL sb_ovf: got %b expected %b", o_overflow, e.ovf); end
        end
      end
    end
  end

  initial begin : mon_w7
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (valid7) begin
        checks++;
        if (sb7_q.size() == 0) begin
          failures++;
          $display("FAIL sb7_unexpected: o_valid with o_bcd=%h but no request pending", bcd7);
        end else begin
          e = sb7_q.pop_front();
          if (bcd7 !== e.bcd) begin failures++; $display("FAIL sb7_bcd: got %h expected %h", bcd7, e.bcd); end
          checks++;
          if (pm7 !== e.pm) begin failures++; $display("FAIL sb7_pm: got %b expected %b", pm7, e.pm); end
          checks++;
          if (ovf7 !== e.ovf) begin failures++; $display("FAIL sb7_ovf: got %b expected %b", ovf7, e.ovf); end
        end
      end
    end
  end

  // Issue one request on the default instance, scramble inputs after accept,
  // then wait for o_valid and check the accept-to-valid edge count.
  task automatic send_and_wait(input logic [17:0] f, input logic m, input logic b, input int exp_lat);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin @(posedge i_clk); #1; n++; end
    sb_q.push_back(model(21'(f), 6, m, b));
    i_fields = f; i_mode_12h = m; i_blank_lz = b; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_fields = ~f; i_mode_12h = ~m; i_blank_lz = ~b;
    n = 0;
    do begin @(posedge i_clk); #1; n++; end while (!o_valid && n < 60);
    checks++;
    if (n != exp_lat) begin
      failures++;
      $display("FAIL latency: got %0d edges expected %0d (o_valid=%b)", n, exp_lat, o_valid);
    end
  endtask

  task automatic test_reset;
    #2 i_reset = 1'b1;
    #1;
    checks++; if (o_bcd !== 24'h0) begin failures++; $display("FAIL reset_bcd: got %h expected 000000", o_bcd); end
    checks++; if (o_pm !== 1'b0) begin failures++; $display("FAIL reset_pm: got %b expected 0", o_pm); end
    checks++; if (o_overflow !== 3'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 000", o_overflow); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
  endtask

  task automatic test_24h;
    send_and_wait({6'd13, 6'd45, 6'd7}, 1'b0, 1'b0, 22);
    checks++; if (o_bcd !== 24'h134507) begin failures++; $display("FAIL h24_bcd: got %h expected 134507", o_bcd); end
    checks++; if (o_pm !== 1'b1) begin failures++; $display("FAIL h24_pm: got %b expected 1", o_pm); end
    repeat (10) @(posedge i_clk);
    #1;
    checks++; if (o_bcd !== 24'h134507 || o_pm !== 1'b1) begin
      failures++; $display("FAIL hold: got %h/%b expected 134507/1", o_bcd, o_pm);
    end
    send_and_wait(18'd0, 1'b0, 1'b0, 22);
    checks++; if (o_bcd !== 24'h000000) begin failures++; $display("FAIL h24_zero: got %h expected 000000", o_bcd); end
    send_and_wait({6'd23, 6'd59, 6'd59}, 1'b0, 1'b1, 22);
    checks++; if (o_bcd !== 24'h235959) begin failures++; $display("FAIL h24_max: got %h expected 235959", o_bcd); end
  endtask

  task automatic test_12h;
    logic [5:0] hr  [6] = '{6'd0, 6'd13, 6'd12, 6'd0, 6'd23, 6'd40};
    logic       blk [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] eh  [6] = '{8'h12, 8'hF1, 8'h12, 8'h12, 8'h11, 8'h40};
    logic       epm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] got;
    for (int k = 0; k < 6; k++) begin
      send_and_wait({hr[k], 6'd30, 6'd9}, 1'b1, blk[k], 22);
      got = o_bcd[23:16];
      checks++;
      if (got !== eh[k] || o_pm !== epm[k]) begin
        failures++;
        $display("FAIL h12_case%0d: got hours %h pm %b expected %h pm %b", k, got, o_pm, eh[k], epm[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int last, pulses, n;
    last = -1; pulses = 0;
    i_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      i_fields = 18'($urandom);
      i_mode_12h = 1'($urandom);
      i_blank_lz = 1'($urandom);
      if (o_ready) sb_q.push_back(model(21'(i_fields), 6, i_mode_12h, i_blank_lz));
      @(posedge i_clk); #1;
      if (o_valid) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 23) begin failures++; $display("FAIL b2b_period: got %0d expected 23", c - last); end
        end
        last = c;
        pulses++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (pulses != 2) begin failures++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin @(posedge i_clk); #1; n++; end
    checks++;
    if (sb_q.size() != 0) begin failures++; $display("FAIL b2b_drain: %0d results still pending expected 0", sb_q.size()); end
  endtask

  task automatic test_reset_abort;
    int seen;
    send_and_wait({6'd23, 6'd59, 6'd59}, 1'b0, 1'b0, 22);
    i_fields = {6'd11, 6'd22, 6'd33}; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (9) @(posedge i_clk);
    #1 i_reset = 1'b1;
    #1;
    checks++;
    if (o_bcd !== 24'h0 || o_pm !== 1'b0 || o_overflow !== 3'b0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_outputs: got bcd=%h pm=%b ovf=%b valid=%b ready=%b expected 000000/0/000/0/1",
               o_bcd, o_pm, o_overflow, o_valid, o_ready);
    end
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    seen = 0;
    repeat (30) begin @(posedge i_clk); #1; if (o_valid) seen++; end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_no_valid: got %0d pulses expected 0", seen); end
    send_and_wait({6'd1, 6'd2, 6'd3}, 1'b0, 1'b0, 22);
    checks++; if (o_bcd !== 24'h010203) begin failures++; $display("FAIL abort_recover: got %h expected 010203", o_bcd); end
  endtask

  task automatic test_overflow;
    logic [20:0] fs [2] = '{{7'd10, 7'd59, 7'd120}, {7'd127, 7'd99, 7'd59}};
    logic [23:0] eb [2] = '{24'h105999, 24'h999959};
    logic [2:0]  eo [2] = '{3'b001, 3'b100};
    int n;
    for (int k = 0; k < 2; k++) begin
      sb7_q.push_back(model(fs[k], 7, 1'b0, 1'b0));
      f7 = fs[k]; v7 = 1'b1;
      @(posedge i_clk); #1;
      v7 = 1'b0; f7 = '1;
      n = 0;
      do begin @(posedge i_clk); #1; n++; end while (!valid7 && n < 60);
      checks++;
      if (n != 25) begin failures++; $display("FAIL w7_latency: got %0d edges expected 25", n); end
      checks++;
      if (bcd7 !== eb[k] || ovf7 !== eo[k]) begin
        failures++;
        $display("FAIL w7_case%0d: got bcd %h ovf %b expected %h ovf %b", k, bcd7, ovf7, eb[k], eo[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_24h();
    test_12h();
    test_back_to_back();
    test_reset_abort();
    test_overflow();
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (sb_q.size() != 0 || sb7_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d/%0d pending expected 0/0", sb_q.size(), sb7_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_to_bcd_seq.md
TIME_TO_BCD_SEQ -- requirements
Module: time_to_bcd_seq

Interface
REQ-001 Parameter NUM_FIELDS, default 3, SHALL set the number of binary time fields (field 0 = seconds, 1 = minutes, 2 = hours).
REQ-002 Parameter BIN_WIDTH, default 6, SHALL set the width of each binary field, legal range 4..7.
REQ-003 Parameter HOURS_IDX, default 2, SHALL select the field subject to 12h conversion and blanking; a value >= NUM_FIELDS disables both.
REQ-004 i_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 i_valid  in  1  SHALL be the request strobe, accepted when i_valid && o_ready at a rising edge.
REQ-007 o_ready  out  1  SHALL be high only in IDLE.
REQ-008 i_fields  in  NUM_FIELDS*BIN_WIDTH  SHALL be the packed binary fields, field 0 in the LSBs.
REQ-009 i_mode_12h  in  1  SHALL select 12h display of the hours field when high.
REQ-010 i_blank_lz  in  1  SHALL request leading-zero blanking of the hours field when high.
REQ-011 o_bcd  out  NUM_FIELDS*8  SHALL carry two BCD nibbles per field, field 0 lowest, units nibble below tens nibble.
REQ-012 o_valid  out  1  SHALL pulse high for one cycle when o_bcd/o_pm/o_overflow update.
REQ-013 o_pm  out  1  SHALL flag hours >= 12 for the last completed request.
REQ-014 o_overflow  out  NUM_FIELDS  SHALL flag, per field, a value above 99 in the last completed request.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, STORE, DONE.
REQ-016 On accept, the block SHALL snapshot i_fields, i_mode_12h and i_blank_lz, set field index 0, load the field-0 shift register and enter SHIFT; inputs are ignored afterwards until IDLE.
REQ-017 SHIFT SHALL run BIN_WIDTH double-dabble cycles (add 3 to any digit >= 5, then shift left 1) and then enter STORE.
REQ-018 STORE SHALL write the current field's digits to an internal result slot; it SHALL load the next field and return to SHIFT, or enter DONE after field NUM_FIELDS-1.
REQ-019 DONE SHALL copy all result slots to o_bcd, o_pm and o_overflow, assert o_valid, and return to IDLE on the next edge.
REQ-020 o_valid SHALL rise NUM_FIELDS*(BIN_WIDTH+1)+1 edges after the accept edge (22 for defaults).
REQ-021 A new request SHALL be acceptable on the edge after o_valid; i_valid held high SHALL give back-to-back conversions with no idle gap beyond the IDLE cycle.
REQ-022 With 12h mode snapshotted, the hours value h SHALL be remapped before conversion: h=0 -> 12, 13..23 -> h-12, otherwise unchanged.
REQ-023 o_pm SHALL be (h >= 12) on the original value in both modes; hours values >= 24 SHALL be converted unmapped, with o_pm=1.
REQ-024 If blanking is snapshotted, 12h mode is active and the hours tens digit is 0, the hours tens nibble SHALL be 4'hF (blank code).
REQ-025 A field value > 99 (possible only with BIN_WIDTH=7) SHALL produce digits 9,9 and set its o_overflow bit.
REQ-026 o_bcd, o_pm and o_overflow SHALL hold their values between o_valid pulses.

Reset
REQ-027 While i_reset is high, the block SHALL be in IDLE with o_bcd=0, o_pm=0, o_overflow=0, o_valid=0 and o_ready=1, independent of i_clk.
REQ-028 Reset during a conversion SHALL abort it; no o_valid SHALL be produced for the aborted request.

Structure
REQ-029 A shared package/header SHALL hold the FSM state encoding, BLANK_CODE=4'hF and the parameter defaults.
REQ-030 The add-3 correction plus shift SHALL be a combinational sub-module, bcd_dd_step, instantiated once and time-shared across fields.
REQ-031 The implementation SHALL use one iterative datapath (not NUM_FIELDS parallel converters).

Verification
REQ-032 Reset, 24h mode, fields sec=7 min=45 hr=13 -> o_valid exactly 22 edges after the accept edge; o_bcd nibbles hr 1,3 / min 4,5 / sec 0,7; o_pm=1.
REQ-033 12h mode, hr=0 -> 1,2 with o_pm=0; hr=13 with blanking -> F,1 with o_pm=1; hr=12 -> 1,2 with o_pm=1.
REQ-034 i_valid held high for 60 cycles -> one o_valid per 23-cycle period; input changes during SHIFT do not affect the result in flight.
REQ-035 i_reset asserted 10 cycles into a conversion -> outputs 0 immediately, o_ready=1, no o_valid; the next request completes correctly.
REQ-036 BIN_WIDTH=7 instance, field value 120 -> digits 9,9 and o_overflow bit set; value 59 -> 5,9 and bit clear.
REQ-037 All fields 0 in 24h mode -> all nibbles 0; 0 hours in 12h mode with blanking -> hours F,2? excluded; the required result is 1,2 (tens digit 1 is not blanked).
